// File: rtl/fifo_rd_packer.sv
// Packs PACK consecutive FIFO read bytes (little-endian) into one output word,
// with flush support for partial words and a ready/valid handshake downstream.
module fifo_rd_packer #(
    parameter int DATAWIDTH = 8,
    parameter int PACK      = 4
) (
    input  logic                          rclk,
    input  logic                          rrst,
    input  logic [DATAWIDTH-1:0]          rdata,
    input  logic                          rempty,
    output logic                          rinc,
    input  logic                          flush,
    output logic [DATAWIDTH*PACK-1:0]     out_data,
    output logic [$clog2(PACK):0]         out_bytes,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   word_cnt
);

    localparam int CW = $clog2(PACK);
    localparam int WW = DATAWIDTH * PACK;
    localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e          state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [WW-1:0]   asm_q,       asm_d;
    logic [WW-1:0]   out_data_q,  out_data_d;
    logic [CW:0]     out_bytes_q, out_bytes_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     word_cnt_q,  word_cnt_d;

    logic            pop;
    logic            last_byte;
    logic [CW:0]     cnt_inc;
    logic [WW-1:0]   asm_merged;

    // Reset is folded in so the FIFO is never popped while rrst holds the state.
    assign rinc      = (state_q == FILL) & ~rempty & ~rrst;
    assign pop       = rinc;
    assign last_byte = (cnt_q == CNT_LAST);
    assign cnt_inc   = {1'b0, cnt_q} + (CW + 1)'(1);

    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;
    assign out_valid = out_valid_q;
    assign word_cnt  = word_cnt_q;

    // Assembly register with the popped byte written into lane cnt.
    always_comb begin
        asm_merged = asm_q;
        for (int i = 0; i < PACK; i++) begin
            if (pop && (cnt_q == CW'(i))) begin
                asm_merged[i*DATAWIDTH +: DATAWIDTH] = rdata;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q;

        case (state_q)
            FILL: begin
                if (pop && (last_byte || flush)) begin
                    state_d     = HOLD;
                    cnt_d       = '0;
                    asm_d       = asm_merged;
                    out_data_d  = asm_merged;
                    out_bytes_d = cnt_inc;
                    out_valid_d = 1'b1;
                end else if (pop) begin
                    cnt_d = cnt_q + CW'(1);
                    asm_d = asm_merged;
                end else if (flush && (cnt_q != '0)) begin
                    // Lanes above cnt are still zero from the last clear.
                    state_d     = HOLD;
                    cnt_d       = '0;
                    out_data_d  = asm_q;
                    out_bytes_d = {1'b0, cnt_q};
                    out_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                    asm_d       = '0;
                    word_cnt_d  = word_cnt_q + 16'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // A presented word must not change or vanish until it is taken.
    assert property (@(posedge rclk) disable iff (rrst)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_bytes_q)));

    assert property (@(posedge rclk) disable iff (rrst)
        (state_q == HOLD) |-> !rinc);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a queue models the FWFT FIFO, each task
// drives one scenario and compares outputs against hand-computed values.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst;
    logic [7:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic        flush;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_cnt;

    logic [7:0]  fifo_q[$];
    logic        gate_empty;
    logic        pop_seen;
    int          checks = 0;
    int          errors = 0;

    fifo_rd_packer #(.DATAWIDTH(8), .PACK(4)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .flush     (flush),
        .out_data  (out_data),
        .out_bytes (out_bytes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    always #5 rclk = ~rclk;

    task automatic refresh();
        rempty = gate_empty || (fifo_q.size() == 0);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // Called at a falling edge; runs one rising edge and returns at the next falling edge.
    task automatic cycle();
        #1;
        pop_seen = rinc && !rempty;
        @(posedge rclk);
        if (pop_seen) void'(fifo_q.pop_front());
        @(negedge rclk);
        refresh();
    endtask

    task automatic do_reset();
        rrst       = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        gate_empty = 1'b0;
        fifo_q.delete();
        refresh();
        @(negedge rclk);
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        fifo_q = '{8'h99};
        gate_empty = 1'b0;
        refresh();
        @(negedge rclk);
        @(negedge rclk);
        checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b expected 0", rinc); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", out_data); end
        checks++; if (out_bytes !== 3'd0) begin errors++; $display("FAIL reset_bytes: got %0d expected 0", out_bytes); end
        checks++; if (word_cnt !== 16'h0) begin errors++; $display("FAIL reset_word_cnt: got %h expected 0000", word_cnt); end
        fifo_q.delete();
        refresh();
        rrst = 1'b0;
    endtask

    task automatic test_basic();
        int pops = 0;
        do_reset();
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        out_ready = 1'b1;
        refresh();
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d]: got %b expected 0", i, out_valid); end
            cycle();
            if (pop_seen) pops++;
        end
        checks++; if (pops !== 4) begin errors++; $display("FAIL basic_pops: got %0d expected 4", pops); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'h04030201) begin errors++; $display("FAIL basic_data: got %h expected 04030201", out_data); end
        checks++; if (out_bytes !== 3'd4) begin errors++; $display("FAIL basic_bytes: got %0d expected 4", out_bytes); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", out_valid); end
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL basic_word_cnt: got %0d expected 1", word_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        fifo_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        out_ready = 1'b0;
        refresh();
        repeat (4) cycle();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h14131211) begin errors++; $display("FAIL b2b_first: got valid=%b data=%h expected valid=1 data=14131211", out_valid, out_data); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL b2b_hold_rinc[%0d]: got %b expected 0", i, rinc); end
            cycle();
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h14131211 || out_bytes !== 3'd4) begin errors++; $display("FAIL b2b_hold_stable[%0d]: got valid=%b data=%h bytes=%0d expected 1 14131211 4", i, out_valid, out_data, out_bytes); end
        end
        out_ready = 1'b1;
        cycle();
        checks++; if (pop_seen !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got pop=%b expected 0", pop_seen); end
        checks++; if (word_cnt !== 16'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept1: got cnt=%0d valid=%b expected 1 0", word_cnt, out_valid); end
        repeat (4) cycle();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h18171615) begin errors++; $display("FAIL b2b_second: got valid=%b data=%h expected valid=1 data=18171615", out_valid, out_data); end
        cycle();
        checks++; if (word_cnt !== 16'd2) begin errors++; $display("FAIL b2b_word_cnt: got %0d expected 2", word_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush_partial();
        do_reset();
        fifo_q = '{8'hA1, 8'hA2, 8'hA3};
        refresh();
        repeat (5) cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fp_no_valid: got %b expected 0", out_valid); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fp_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'h00A3A2A1) begin errors++; $display("FAIL fp_data: got %h expected 00A3A2A1", out_data); end
        checks++; if (out_bytes !== 3'd3) begin errors++; $display("FAIL fp_bytes: got %0d expected 3", out_bytes); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_bytes !== 3'd3 || out_data !== 32'h00A3A2A1) begin errors++; $display("FAIL fp_flush_in_hold: got valid=%b bytes=%0d data=%h expected 1 3 00A3A2A1", out_valid, out_bytes, out_data); end
        out_ready = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b0 || word_cnt !== 16'd1) begin errors++; $display("FAIL fp_accept: got valid=%b cnt=%0d expected 0 1", out_valid, word_cnt); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush_with_pop();
        do_reset();
        fifo_q = '{8'h55, 8'h66};
        refresh();
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++; if (pop_seen !== 1'b1) begin errors++; $display("FAIL fwp_pop: got %b expected 1", pop_seen); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h00006655 || out_bytes !== 3'd2) begin errors++; $display("FAIL fwp_word: got valid=%b data=%h bytes=%0d expected 1 00006655 2", out_valid, out_data, out_bytes); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL fwp_word_cnt: got %0d expected 1", word_cnt); end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fwp_empty_flush: got %b expected 0", out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b0 || word_cnt !== 16'd1) begin errors++; $display("FAIL fwp_empty_flush_late: got valid=%b cnt=%0d expected 0 1", out_valid, word_cnt); end
    endtask

    task automatic test_rempty_gaps();
        do_reset();
        fifo_q = '{8'h21, 8'h22, 8'h23, 8'h24};
        refresh();
        repeat (2) cycle();
        gate_empty = 1'b1;
        refresh();
        repeat (3) cycle();
        checks++; if (out_valid !== 1'b0 || fifo_q.size() != 2) begin errors++; $display("FAIL gap_hold: got valid=%b left=%0d expected 0 2", out_valid, fifo_q.size()); end
        gate_empty = 1'b0;
        refresh();
        repeat (2) cycle();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h24232221 || out_bytes !== 3'd4) begin errors++; $display("FAIL gap_word: got valid=%b data=%h bytes=%0d expected 1 24232221 4", out_valid, out_data, out_bytes); end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        fifo_q = '{8'h31, 8'h32, 8'h33, 8'h34};
        out_ready = 1'b1;
        refresh();
        repeat (5) cycle();
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL rmw_pre_cnt: got %0d expected 1", word_cnt); end
        out_ready = 1'b0;
        fifo_q = '{8'hEE, 8'hEF};
        refresh();
        repeat (2) cycle();
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        refresh();
        #2;
        rrst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_bytes !== 3'd0 || word_cnt !== 16'd0 || rinc !== 1'b0) begin errors++; $display("FAIL rmw_async: got valid=%b data=%h bytes=%0d cnt=%0d rinc=%b expected all 0", out_valid, out_data, out_bytes, word_cnt, rinc); end
        @(negedge rclk);
        rrst = 1'b0;
        refresh();
        repeat (2) cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmw_discard: got valid=%b data=%h expected valid 0", out_valid, out_data); end
        repeat (2) cycle();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_bytes !== 3'd4) begin errors++; $display("FAIL rmw_word: got valid=%b data=%h bytes=%0d expected 1 04030201 4", out_valid, out_data, out_bytes); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL rmw_word_cnt: got %0d expected 1", word_cnt); end
    endtask

    task automatic test_word_cnt_wrap();
        do_reset();
        for (int i = 0; i < 300; i++) fifo_q.push_back(8'(i));
        flush = 1'b1;
        out_ready = 1'b1;
        refresh();
        repeat (600) cycle();
        checks++; if (word_cnt !== 16'd300 || fifo_q.size() != 0) begin errors++; $display("FAIL wrap_count300: got cnt=%0d left=%0d expected 300 0", word_cnt, fifo_q.size()); end
        checks++; if (out_bytes !== 3'd1) begin errors++; $display("FAIL wrap_single_bytes: got %0d expected 1", out_bytes); end
        // Jump close to the wrap point rather than clocking 65536 words.
        force dut.word_cnt_q = 16'hFFFD;
        #1;
        release dut.word_cnt_q;
        checks++; if (word_cnt !== 16'hFFFD) begin errors++; $display("FAIL wrap_preload: got %h expected FFFD", word_cnt); end
        fifo_q = '{8'hC1, 8'hC2, 8'hC3};
        refresh();
        repeat (4) cycle();
        checks++; if (word_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h expected FFFF", word_cnt); end
        repeat (2) cycle();
        checks++; if (word_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", word_cnt); end
        flush = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rrst       = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        gate_empty = 1'b0;
        pop_seen   = 1'b0;
        refresh();
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush_partial();
        test_flush_with_pop();
        test_rempty_gaps();
        test_reset_mid_word();
        test_word_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning FIFO read-data byte width.
REQ-002 SHALL have parameter PACK, default 4, meaning bytes packed per output word (power of 2, >=2).
REQ-003 SHALL have port rclk  input  1  single clock, the FIFO read-domain clock; all logic on rising edge.
REQ-004 SHALL have port rrst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rdata  input  DATAWIDTH  FIFO read data, valid whenever rempty=0 (first-word-fall-through).
REQ-006 SHALL have port rempty  input  1  FIFO empty flag.
REQ-007 SHALL have port rinc  output  1  FIFO pop strobe; the FIFO advances on rclk edge when rinc=1 and rempty=0.
REQ-008 SHALL have port flush  input  1  single-cycle request to emit a partially filled word.
REQ-009 SHALL have port out_data  output  DATAWIDTH*PACK  packed word.
REQ-010 SHALL have port out_bytes  output  clog2(PACK)+1  number of valid bytes in out_data (1..PACK).
REQ-011 SHALL have port out_valid  output  1  out_data/out_bytes valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts word when out_valid=1 and out_ready=1.
REQ-013 SHALL have port word_cnt  output  16  count of words accepted downstream, wraps 0xFFFF->0x0000.

Function
REQ-014 SHALL implement two states: FILL (collecting bytes) and HOLD (presenting word).
REQ-015 SHALL drive rinc = (state==FILL) & ~rempty, combinationally; rinc SHALL be 0 in HOLD and during reset.
REQ-016 SHALL, on each pop (rinc=1), write rdata into byte lane cnt of the assembly register (lane 0 = bits [DATAWIDTH-1:0], little-endian) and increment cnt.
REQ-017 SHALL, on a pop with cnt==PACK-1, transition to HOLD next cycle with out_valid=1, out_bytes=PACK, cnt cleared to 0.
REQ-018 SHALL, on flush=1 in FILL with no pop and cnt>0, transition to HOLD with out_bytes=cnt.
REQ-019 SHALL, on flush=1 coincident with a pop, include the popped byte and transition to HOLD with out_bytes=cnt+1.
REQ-020 SHALL ignore flush when cnt==0 and no pop occurs, and ignore flush in HOLD.
REQ-021 SHALL drive unused byte lanes of out_data to zero for partial words.
REQ-022 SHALL hold out_data and out_bytes stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, in HOLD on out_ready=1, return to FILL next cycle, clear out_valid and the assembly register, and increment word_cnt by 1.
REQ-024 SHALL impose one bubble cycle between word acceptance and the next pop (no pop in the acceptance cycle).
REQ-025 SHALL have latency: out_valid asserts the cycle after the PACK-th pop or qualifying flush.
REQ-026 SHALL tolerate rempty toggling mid-word; cnt holds while rempty=1, and no timeout exists.

Reset
REQ-027 SHALL, while rrst=1, asynchronously force state=FILL, cnt=0, assembly register=0, out_data=0, out_bytes=0, out_valid=0, word_cnt=0, rinc=0.
REQ-028 SHALL, on reset asserted mid-word or in HOLD, discard partial or pending data with no word emitted.
REQ-029 SHALL resume normal operation on the first rclk edge after rrst deasserts.

Verification
REQ-030 SHALL verify: FIFO holds 1,2,3,4 and out_ready=1 -> 4 pops on consecutive cycles, then out_data=0x04030201, out_bytes=4, out_valid for 1 cycle, word_cnt=1.
REQ-031 SHALL verify: 8 bytes 0x11..0x18 with out_ready=0 for 5 cycles after first word -> rinc=0 throughout HOLD, out_data stable at 0x14131211, then 0x18171615 after release; word_cnt=2.
REQ-032 SHALL verify: 3 bytes 0xA1,0xA2,0xA3 then rempty=1 and flush pulse -> out_data=0x00A3A2A1, out_bytes=3.
REQ-033 SHALL verify: flush coincident with 2nd pop (0x55,0x66) -> out_data=0x00006655, out_bytes=2; flush with cnt=0 and rempty=1 -> no out_valid.
REQ-034 SHALL verify: rrst pulse after 2 pops -> all outputs 0 immediately; next 4 bytes 0x01..0x04 produce 0x04030201 only.
REQ-035 SHALL verify: 65536 accepted words -> word_cnt wraps to 0x0000.
